ram_2port_be: RTL



---
 rtl/ram_2port_be_if.sv | 34 +++
 rtl/ram_2port_be.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ram_2port_be_if.sv
// Bus bundle for ram_2port_be: both access ports plus the status flags.
// The slave modport is the RAM side and the master modport is the client side.
interface ram_2port_be_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 9,
  parameter int BWIDTH = 8
);
  localparam int NB = DWIDTH / BWIDTH;

  logic              ena;
  logic [NB-1:0]     wea;
  logic [AWIDTH-1:0] addra;
  logic [DWIDTH-1:0] dia;
  logic [DWIDTH-1:0] doa;
  logic              vala;
  logic              enb;
  logic [NB-1:0]     web;
  logic [AWIDTH-1:0] addrb;
  logic [DWIDTH-1:0] dib;
  logic [DWIDTH-1:0] dob;
  logic              valb;
  logic              collision;
  logic              busy;

  modport master (
    output ena, wea, addra, dia, enb, web, addrb, dib,
    input  doa, vala, dob, valb, collision, busy
  );

  modport slave (
    input  ena, wea, addra, dia, enb, web, addrb, dib,
    output doa, vala, dob, valb, collision, busy
  );
endinterface

// File: rtl/ram_2port_be.sv
// Single-clock true dual-port RAM with byte-lane write enables, a read latency of 1 or 2, and selectable read-during-write.
// Defining RAM_CLEAR_EN adds a zeroing sweep after reset, with busy held high until the sweep finishes.
module ram_2port_be #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 9,
  parameter int BWIDTH      = 8,
  parameter int READ_LAT    = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  ram_2port_be_if.slave  bus
);
  localparam int NB    = DWIDTH / BWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  generate
    if (DWIDTH % BWIDTH != 0) begin : g_bad_width
      $error("ram_2port_be: DWIDTH must be a multiple of BWIDTH");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("ram_2port_be: READ_LAT must be 1 or 2");
    end
  endgenerate

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [AWIDTH-1:0] w_clr_addr;
  logic              w_acc_a;
  logic              w_acc_b;
  logic [DWIDTH-1:0] w_old_a;
  logic [DWIDTH-1:0] w_old_b;
  logic [DWIDTH-1:0] w_merge_a;
  logic [DWIDTH-1:0] w_merge_b;
  logic [DWIDTH-1:0] w_rd_a;
  logic [DWIDTH-1:0] w_rd_b;

  logic              r_va_a1;
  logic              r_va_b1;
  logic [DWIDTH-1:0] r_do_a1;
  logic [DWIDTH-1:0] r_do_b1;
  logic              r_collision;

`ifdef RAM_CLEAR_EN
  logic              r_clr_active;
  logic [AWIDTH-1:0] r_clr_addr;

  // Reset parks the sweep at address 0, so a mid-sweep reset restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_active <= 1'b1;
      r_clr_addr   <= '0;
    end else if (r_clr_active) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == {AWIDTH{1'b1}}) begin
        r_clr_active <= 1'b0;
      end
    end
  end

  assign w_busy     = r_clr_active;
  assign w_clr_we   = r_clr_active & ~rst;
  assign w_clr_addr = r_clr_addr;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_acc_a = bus.ena & ~w_busy & ~rst;
  assign w_acc_b = bus.enb & ~w_busy & ~rst;
  assign w_old_a = r_mem[bus.addra];
  assign w_old_b = r_mem[bus.addrb];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merge_a[gi*BWIDTH +: BWIDTH] = bus.wea[gi] ? bus.dia[gi*BWIDTH +: BWIDTH]
                                                          : w_old_a[gi*BWIDTH +: BWIDTH];
      assign w_merge_b[gi*BWIDTH +: BWIDTH] = bus.web[gi] ? bus.dib[gi*BWIDTH +: BWIDTH]
                                                          : w_old_b[gi*BWIDTH +: BWIDTH];
    end
  endgenerate

  // Write-first merges only the port's own lanes; a write from the other port is never visible in the same cycle.
  assign w_rd_a = (WRITE_FIRST != 0) ? w_merge_a : w_old_a;
  assign w_rd_b = (WRITE_FIRST != 0) ? w_merge_b : w_old_b;

  // Port A lanes are written after port B lanes, so port A wins any overlapping lane.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_acc_b && bus.web[i]) begin
          r_mem[bus.addrb][i*BWIDTH +: BWIDTH] <= bus.dib[i*BWIDTH +: BWIDTH];
        end
        if (w_acc_a && bus.wea[i]) begin
          r_mem[bus.addra][i*BWIDTH +: BWIDTH] <= bus.dia[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_va_a1     <= 1'b0;
      r_va_b1     <= 1'b0;
      r_do_a1     <= '0;
      r_do_b1     <= '0;
      r_collision <= 1'b0;
    end else begin
      r_va_a1     <= w_acc_a;
      r_va_b1     <= w_acc_b;
      r_collision <= w_acc_a & w_acc_b & (bus.addra == bus.addrb) & (|(bus.wea & bus.web));
      if (w_acc_a) begin
        r_do_a1 <= w_rd_a;
      end
      if (w_acc_b) begin
        r_do_b1 <= w_rd_b;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_va_a2;
      logic              r_va_b2;
      logic [DWIDTH-1:0] r_do_a2;
      logic [DWIDTH-1:0] r_do_b2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_va_a2 <= 1'b0;
          r_va_b2 <= 1'b0;
          r_do_a2 <= '0;
          r_do_b2 <= '0;
        end else begin
          r_va_a2 <= r_va_a1;
          r_va_b2 <= r_va_b1;
          if (r_va_a1) begin
            r_do_a2 <= r_do_a1;
          end
          if (r_va_b1) begin
            r_do_b2 <= r_do_b1;
          end
        end
      end

      assign bus.doa  = r_do_a2;
      assign bus.vala = r_va_a2;
      assign bus.dob  = r_do_b2;
      assign bus.valb = r_va_b2;
    end else begin : g_lat1
      assign bus.doa  = r_do_a1;
      assign bus.vala = r_va_a1;
      assign bus.dob  = r_do_b1;
      assign bus.valb = r_va_b1;
    end
  endgenerate

  assign bus.collision = r_collision;
  assign bus.busy      = w_busy;
endmodule
